// File: rtl/motor_pkg.sv
// Shared types for the stepper move path: FSM states, direction
// codes and the coil phase one-hot lookup.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } move_state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic logic [3:0] coil_of(input logic [1:0] ph);
    logic [3:0] c;
    c = 4'b0001;
    unique case (ph)
      2'd0: c = 4'b0001;
      2'd1: c = 4'b0010;
      2'd2: c = 4'b0100;
      2'd3: c = 4'b1000;
      default: c = 4'b0001;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/step_phase_seq.sv
// Coil phase ring S1..S4; advances one position per enabled cycle,
// forward or reverse, and holds otherwise.
module step_phase_seq
  import motor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  output logic [1:0] phase,
  output logic [3:0] coil
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= 2'd0;
    end else if (en) begin
      if (dir == DIR_REV) phase <= phase - 2'd1;
      else                phase <= phase + 2'd1;
    end
  end

  assign coil = coil_of(phase);

endmodule

// File: rtl/step_move_ctrl.sv
// Single-move step scheduler: paces step strobes and drives the phase ring.
// Optional accel ramp enabled by defining STEP_RAMP_EN.
module step_move_ctrl
  import motor_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int PER_W      = 16,
  parameter int RAMP_SHIFT = 2,
  parameter int RAMP_DEC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_dir,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             step_pulse,
  output logic [1:0]       phase,
  output logic [3:0]       coil,
  output logic [CNT_W-1:0] steps_left
);

  move_state_t      state, state_nx;
  logic [CNT_W-1:0] left_q;
  logic [PER_W-1:0] timer_q;
  logic [PER_W-1:0] per_q;
  logic             dir_q;

  logic             accept;
  logic             strobe;
  logic [PER_W-1:0] p_cmd;
  logic [PER_W-1:0] first_tmr;
  logic [PER_W-1:0] reload;

  assign p_cmd  = (cmd_period == '0) ? PER_W'(1) : cmd_period;
  assign accept = cmd_valid & cmd_ready;
  // abort wins over a strobe landing in the same cycle
  assign strobe = (state == ST_RUN) && (timer_q == '0) && !abort;

`ifdef STEP_RAMP_EN
  localparam int XW = PER_W + RAMP_SHIFT;
  localparam logic [XW-1:0] PER_MAX = XW'({PER_W{1'b1}});

  logic [PER_W-1:0] cur_q;
  logic [XW-1:0]    start_w;
  logic [PER_W-1:0] start_per;
  logic [PER_W:0]   floor_w;
  logic [PER_W-1:0] next_per;

  assign start_w   = XW'(p_cmd) << RAMP_SHIFT;
  assign start_per = (start_w > PER_MAX) ? {PER_W{1'b1}}
                                         : start_w[PER_W-1:0];
  assign floor_w   = {1'b0, per_q} + (PER_W+1)'(RAMP_DEC);
  assign next_per  = ({1'b0, cur_q} < floor_w) ? per_q
                                               : cur_q - PER_W'(RAMP_DEC);
  assign first_tmr = start_per - PER_W'(1);
  assign reload    = next_per - PER_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_q <= '0;
    end else if (accept) begin
      cur_q <= start_per;
    end else if (strobe) begin
      cur_q <= next_per;
    end
  end
`else
  assign first_tmr = p_cmd - PER_W'(1);
  assign reload    = per_q - PER_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = reset;
        if (accept) begin
          if (cmd_count == '0) state_nx = ST_FIN;
          else                 state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort) state_nx = ST_FIN;
        else if (strobe && left_q == CNT_W'(1)) state_nx = ST_FIN;
      end
      ST_FIN: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
      left_q  <= '0;
      per_q   <= '0;
      dir_q   <= DIR_FWD;
    end else if (accept) begin
      timer_q <= first_tmr;
      left_q  <= cmd_count;
      per_q   <= p_cmd;
      dir_q   <= cmd_dir;
    end else if (state == ST_RUN && !abort) begin
      if (timer_q != '0) begin
        timer_q <= timer_q - PER_W'(1);
      end else begin
        timer_q <= reload;
        if (left_q != '0) left_q <= left_q - CNT_W'(1);
      end
    end
  end

  step_phase_seq u_seq (
    .clk   (clk),
    .reset (reset),
    .en    (strobe),
    .dir   (dir_q),
    .phase (phase),
    .coil  (coil)
  );

  assign step_pulse = strobe;
  assign steps_left = left_q;

endmodule
